serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/serial_loader.sv | 121 ++++++++++++
 tb/tb_serial_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_loader.sv
// serial_loader: gathers an LSB-first serial frame into an 8-bit word
// and loads it into a downstream register with a one-cycle strobe.
module serial_loader #(
    parameter int PARITY_EN = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SSTART,
    input  logic       SVALID,
    input  logic       SIN,
    output logic [7:0] DATA,
    output logic       ENA,
    output logic       PERR,
    output logic       BUSY
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] PAR   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       ena_q, ena_d;
    logic       perr_q, perr_d;

    // Shift register with the current serial bit dropped into slot k.
    logic [7:0] shreg_ins;

    // Insert the incoming bit at the current bit position.
    always_comb begin
        shreg_ins = shreg_q;
        shreg_ins[cnt_q] = SIN;
    end

    // Next-state, bit counter, word assembly and output strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        ena_d   = 1'b0;
        perr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (SSTART) begin
                    state_d = SHIFT;
                    cnt_d   = 3'd0;
                    shreg_d = 8'h00;
                end
            end
            SHIFT: begin
                if (SVALID) begin
                    shreg_d = shreg_ins;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        if (PARITY_EN != 0) begin
                            state_d = PAR;
                        end else begin
                            state_d = DONE;
                            data_d  = shreg_ins;
                            ena_d   = 1'b1;
                        end
                    end
                end
            end
            PAR: begin
                if (SVALID) begin
                    state_d = DONE;
                    // Even parity: the parity bit matches the XOR of data.
                    if (SIN == ^shreg_q) begin
                        data_d = shreg_q;
                        ena_d  = 1'b1;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            DONE: begin
                // Serial input here belongs to no frame and is dropped.
                if (SSTART) begin
                    state_d = SHIFT;
                    cnt_d   = 3'd0;
                    shreg_d = 8'h00;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously by RST.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            ena_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            ena_q   <= ena_d;
            perr_q  <= perr_d;
        end
    end

    assign DATA = data_q;
    assign ENA  = ena_q;
    assign PERR = perr_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_serial_loader.sv
// tb_serial_loader: directed scenarios for serial_loader with
// hand-computed expected words, strobes and timing.
module tb_serial_loader;

    logic       CLK;
    logic       RST;
    logic       SSTART;
    logic       SVALID;
    logic       SIN;
    logic [7:0] DATA;
    logic       ENA;
    logic       PERR;
    logic       BUSY;

    int n_pass;
    int n_total;

    serial_loader #(.PARITY_EN(1)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .SSTART (SSTART),
        .SVALID (SVALID),
        .SIN    (SIN),
        .DATA   (DATA),
        .ENA    (ENA),
        .PERR   (PERR),
        .BUSY   (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_frame();
        SSTART = 1'b1;
        step();
        SSTART = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        SVALID = 1'b1;
        SIN    = b;
        step();
        SVALID = 1'b0;
        SIN    = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #3;
        n_total++;
        if ({DATA, ENA, PERR, BUSY} !== 11'h000) begin
            $display("FAIL reset_async: got %h/%b/%b/%b want 00/0/0/0",
                     DATA, ENA, PERR, BUSY);
        end else n_pass++;
        step();
        step();
        @(negedge CLK);
        RST = 1'b1;
        step();
        step();
        n_total++;
        if (DATA !== 8'h00) $display("FAIL reset_data: got %h want 00", DATA);
        else n_pass++;
        n_total++;
        if ({ENA, PERR, BUSY} !== 3'b000) begin
            $display("FAIL reset_flags: got %b%b%b want 000", ENA, PERR, BUSY);
        end else n_pass++;
    endtask

    task automatic test_good_frame();
        logic [7:0] w;
        int ena_seen;
        w = 8'hA5;
        ena_seen = 0;
        start_frame();
        n_total++;
        if (BUSY !== 1'b1) $display("FAIL good_busy: got %b want 1", BUSY);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i]);
            if (ENA === 1'b1) ena_seen++;
        end
        n_total++;
        if (ena_seen != 0) $display("FAIL good_early_ena: got %0d want 0", ena_seen);
        else n_pass++;
        send_bit(1'b0);
        n_total++;
        if (ENA !== 1'b1 || DATA !== 8'hA5) begin
            $display("FAIL good_load: got ena=%b data=%h want 1/a5", ENA, DATA);
        end else n_pass++;
        n_total++;
        if (PERR !== 1'b0) $display("FAIL good_perr: got %b want 0", PERR);
        else n_pass++;
        step();
        n_total++;
        if ({ENA, BUSY} !== 2'b00 || DATA !== 8'hA5) begin
            $display("FAIL good_after: got ena=%b busy=%b data=%h want 0/0/a5",
                     ENA, BUSY, DATA);
        end else n_pass++;
    endtask

    task automatic test_parity_error();
        logic [7:0] w;
        w = 8'h3C;
        start_frame();
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        send_bit(1'b1);
        n_total++;
        if (PERR !== 1'b1 || ENA !== 1'b0) begin
            $display("FAIL perr_pulse: got perr=%b ena=%b want 1/0", PERR, ENA);
        end else n_pass++;
        n_total++;
        if (DATA !== 8'hA5) $display("FAIL perr_data: got %h want a5", DATA);
        else n_pass++;
        step();
        n_total++;
        if ({PERR, ENA, BUSY} !== 3'b000 || DATA !== 8'hA5) begin
            $display("FAIL perr_after: got perr=%b ena=%b busy=%b data=%h want 0/0/0/a5",
                     PERR, ENA, BUSY, DATA);
        end else n_pass++;
    endtask

    task automatic test_stall();
        int steps;
        int early;
        early = 0;
        steps = 0;
        start_frame();
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                for (int s = 0; s < 3; s++) begin
                    SSTART = 1'b1;
                    SVALID = 1'b0;
                    SIN    = 1'b1;
                    step();
                    steps++;
                    if (ENA === 1'b1 || BUSY !== 1'b1) early++;
                end
                SSTART = 1'b0;
            end
            send_bit(1'b1);
            steps++;
            if (ENA === 1'b1) early++;
        end
        n_total++;
        if (early != 0 || steps != 11) begin
            $display("FAIL stall_hold: got bad=%0d steps=%0d want 0/11", early, steps);
        end else n_pass++;
        send_bit(1'b0);
        n_total++;
        if (ENA !== 1'b1 || DATA !== 8'hFF || PERR !== 1'b0) begin
            $display("FAIL stall_load: got ena=%b data=%h perr=%b want 1/ff/0",
                     ENA, DATA, PERR);
        end else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        int gap;
        int guard;
        w = 8'h01;
        start_frame();
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        send_bit(1'b1);
        n_total++;
        if (ENA !== 1'b1 || DATA !== 8'h01) begin
            $display("FAIL b2b_first: got ena=%b data=%h want 1/01", ENA, DATA);
        end else n_pass++;
        SSTART = 1'b1;
        SVALID = 1'b1;
        SIN    = 1'b1;
        step();
        SSTART = 1'b0;
        SVALID = 1'b0;
        SIN    = 1'b0;
        gap = 0;
        if (ENA === 1'b0) gap++;
        n_total++;
        if (BUSY !== 1'b1) $display("FAIL b2b_restart: got busy=%b want 1", BUSY);
        else n_pass++;
        w = 8'h80;
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i]);
            if (ENA === 1'b0) gap++;
        end
        guard = 0;
        SVALID = 1'b1;
        SIN    = 1'b1;
        step();
        SVALID = 1'b0;
        SIN    = 1'b0;
        while (ENA !== 1'b1 && guard < 20) begin
            gap++;
            guard++;
            step();
        end
        n_total++;
        if (gap != 9) $display("FAIL b2b_gap: got %0d want 9", gap);
        else n_pass++;
        n_total++;
        if (ENA !== 1'b1 || DATA !== 8'h80) begin
            $display("FAIL b2b_second: got ena=%b data=%h want 1/80", ENA, DATA);
        end else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] w;
        int ena_seen;
        w = 8'h55;
        ena_seen = 0;
        start_frame();
        for (int i = 0; i < 5; i++) send_bit(w[i]);
        #2;
        RST = 1'b0;
        #1;
        n_total++;
        if (BUSY !== 1'b0 || DATA !== 8'h00) begin
            $display("FAIL rstmid_async: got busy=%b data=%h want 0/00", BUSY, DATA);
        end else n_pass++;
        for (int i = 0; i < 3; i++) begin
            SVALID = 1'b1;
            SIN    = 1'b1;
            step();
            if (ENA === 1'b1 || PERR === 1'b1) ena_seen++;
        end
        SVALID = 1'b0;
        SIN    = 1'b0;
        n_total++;
        if (ena_seen != 0) $display("FAIL rstmid_strobe: got %0d want 0", ena_seen);
        else n_pass++;
        @(negedge CLK);
        RST = 1'b1;
        start_frame();
        n_total++;
        if (BUSY !== 1'b1) $display("FAIL rstmid_first_start: got %b want 1", BUSY);
        else n_pass++;
        w = 8'h0F;
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        send_bit(1'b0);
        n_total++;
        if (ENA !== 1'b1 || DATA !== 8'h0F || PERR !== 1'b0) begin
            $display("FAIL rstmid_reload: got ena=%b data=%h perr=%b want 1/0f/0",
                     ENA, DATA, PERR);
        end else n_pass++;
        step();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        SSTART  = 1'b0;
        SVALID  = 1'b0;
        SIN     = 1'b0;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
